// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 is illegal)
//   - sequencing FSM state encoding (ST_CLEAR / ST_RUN)
//   - lane enable and alignment helpers
//   - response pipeline stage record
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One stage of the load/fault response pipeline.
    typedef struct packed {
        logic        valid;
        logic        mis;
        logic [31:0] word;
        logic [1:0]  lo;
        logic [1:0]  size;
        logic        uns;
    } rsp_t;

    // Little-endian lane enables: byte k lives in bits [8k+7:8k].
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load lane extraction and extension.
// Ports:
//   i_word      32-bit array word as sampled at request acceptance
//   i_lo        byte address bits [1:0]
//   i_size      access size (byte / halfword / word)
//   i_unsigned  1 = zero-extend, 0 = sign-extend (ignored for words)
//   o_data      right-justified, extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (i_lo)
            2'd0:    b = i_word[7:0];
            2'd1:    b = i_word[15:8];
            2'd2:    b = i_word[23:16];
            default: b = i_word[31:24];
        endcase
        h = i_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: o_data = i_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// data_ram: single-port, byte-addressed, word-organised data memory.
// Optional feature macro: DATA_RAM_CLEAR_EN -- when defined, a post-reset
// sweep zeroes every word (o_busy high, o_ready low) before requests are
// accepted. When undefined, o_ready is 1 from reset and contents persist.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_req/i_we/i_size     request valid, store flag, access size
//   i_unsigned            load zero-extension select
//   i_addr, i_data        byte address, right-justified store data
//   o_ready               request accepted when i_req && o_ready
//   o_rvalid/o_data       response pulse and load data, RD_LATENCY after accept
//   o_misalign            qualifies o_rvalid: access faulted
//   o_busy                clear sweep in progress
module data_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic [31:0]           o_data,
    output logic                  o_misalign,
    output logic                  o_busy
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lo;
    logic             accept;
    logic             mis;
    logic             st_wr;
    logic [3:0]       be;
    logic [31:0]      wdata;

    assign idx    = i_addr[ADDR_WIDTH-1:2];
    assign lo     = i_addr[1:0];
    assign accept = i_req && o_ready;
    assign mis    = misaligned(i_size, lo);
    assign st_wr  = accept && i_we && !mis;
    assign be     = lane_enable(i_size, lo);

    // Replicate store data across lanes so the lane enables pick the right copy.
    always_comb begin
        case (i_size)
            SZ_BYTE: wdata = {4{i_data[7:0]}};
            SZ_HALF: wdata = {2{i_data[15:0]}};
            default: wdata = i_data;
        endcase
    end

`ifdef DATA_RAM_CLEAR_EN
    state_t           state;
    logic [IDX_W-1:0] clr_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + IDX_W'(1);
                    if (clr_idx == IDX_W'(DEPTH - 1)) begin
                        state   <= ST_RUN;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
`else
    assign o_ready = 1'b1;
    assign o_busy  = 1'b0;
`endif

    // Array has no reset; during the sweep o_ready is low so no store competes.
    always_ff @(posedge i_clk) begin
`ifdef DATA_RAM_CLEAR_EN
        if (state == ST_CLEAR)
            mem[clr_idx] <= '0;
        else
`endif
        if (st_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Response pipeline: stage 0 captures the raw word at the accepting edge,
    // the output register fires RD_LATENCY edges after acceptance.
    rsp_t        pipe [RD_LATENCY];
    rsp_t        last;
    logic [31:0] ld_data;

    assign last = pipe[RD_LATENCY-1];

    load_align u_load_align (
        .i_word     (last.word),
        .i_lo       (last.lo),
        .i_size     (last.size),
        .i_unsigned (last.uns),
        .o_data     (ld_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < RD_LATENCY; k++)
                pipe[k] <= '0;
            o_rvalid   <= 1'b0;
            o_data     <= '0;
            o_misalign <= 1'b0;
        end else begin
            pipe[0].valid <= accept && (!i_we || mis);
            pipe[0].mis   <= mis;
            pipe[0].word  <= mem[idx];
            pipe[0].lo    <= lo;
            pipe[0].size  <= i_size;
            pipe[0].uns   <= i_unsigned;
            for (int k = 1; k < RD_LATENCY; k++)
                pipe[k] <= pipe[k-1];
            o_rvalid   <= last.valid;
            o_misalign <= last.valid && last.mis;
            o_data     <= (last.valid && !last.mis) ? ld_data : '0;
        end
    end

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

    localparam int AW  = 8;
    localparam int LAT = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req = 1'b0;
    logic          i_we = 1'b0;
    logic [1:0]    i_size = 2'b00;
    logic          i_unsigned = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [31:0]   i_data = '0;
    logic          o_ready;
    logic          o_rvalid;
    logic [31:0]   o_data;
    logic          o_misalign;
    logic          o_busy;

    data_ram #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_rvalid   (o_rvalid),
        .o_data     (o_data),
        .o_misalign (o_misalign),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem_m [256];
    int         vecs = 0;
    int         errs = 0;

`ifdef DATA_RAM_CLEAR_EN
    localparam logic EXP_READY_RST = 1'b0;
    localparam logic EXP_BUSY_RST  = 1'b1;
    localparam int   EXP_SWEEP     = 64;
`else
    localparam logic EXP_READY_RST = 1'b1;
    localparam logic EXP_BUSY_RST  = 1'b0;
    localparam int   EXP_SWEEP     = 0;
`endif

    // Reference model: byte-wide memory, loads assembled little-endian.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input int addr);
        int nb = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++)
            v = v | (32'(mem_m[addr + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1])
            v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor / scoreboard.
    exp_t e;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_rvalid) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_rvalid: got data=%h mis=%0d at cycle %0d, required no response",
                             o_data, o_misalign, cyc);
                end else begin
                    e = q.pop_front();
                    if (o_data !== e.data || o_misalign !== e.mis || cyc != e.due) begin
                        errs++;
                        $display("FAIL response: got data=%h mis=%0d cycle=%0d, required data=%h mis=%0d cycle=%0d",
                                 o_data, o_misalign, cyc, e.data, e.mis, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                vecs++;
                errs++;
                $display("FAIL missing_rvalid: got no response at cycle %0d, required data=%h mis=%0d",
                         cyc, q[0].data, q[0].mis);
                void'(q.pop_front());
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [7:0] addr, input logic [31:0] data);
        int   g;
        int   nb;
        logic misa;
        exp_t x;
        @(negedge i_clk);
        g = 0;
        while (!o_ready && g < 300) begin
            @(negedge i_clk);
            g++;
        end
        if (!o_ready) begin
            vecs++;
            errs++;
            $display("FAIL ready_timeout: got o_ready=0 after %0d cycles, required 1", g);
            i_req = 1'b0;
            return;
        end
        i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = addr; i_data = data;
        nb   = 1 << sz;
        misa = (sz == 2'd3) || ((int'(addr) % nb) != 0);
        x.due = cyc + 1 + LAT;
        if (misa) begin
            x.data = '0; x.mis = 1'b1;
            q.push_back(x);
        end else if (we) begin
            for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = 8'(data >> (8 * i));
        end else begin
            x.data = model_load(sz, uns, int'(addr)); x.mis = 1'b0;
            q.push_back(x);
        end
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_req = 1'b0;
        i_we  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 50) begin
            @(negedge i_clk);
            g++;
        end
        if (q.size() > 0) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", q.size());
            q.delete();
        end
    endtask

    // Called on the negedge where reset was just released.
    task automatic busy_count(input string name);
        int cnt = 0;
        while (o_busy && cnt < 200) begin
            @(negedge i_clk);
            cnt++;
        end
        check(name, 32'(cnt), 32'(EXP_SWEEP));
        check({name, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] sz;
        int r;

        repeat (3) @(negedge i_clk);
        check("rst_rvalid",   32'(o_rvalid),   32'd0);
        check("rst_data",     o_data,          32'd0);
        check("rst_misalign", 32'(o_misalign), 32'd0);
        check("rst_ready",    32'(o_ready),    32'(EXP_READY_RST));
        check("rst_busy",     32'(o_busy),     32'(EXP_BUSY_RST));
`ifdef DATA_RAM_CLEAR_EN
        model_clear();
`endif
        i_rst = 1'b0;
        busy_count("sweep_cycles");

`ifdef DATA_RAM_CLEAR_EN
        issue(1'b0, 2'b10, 1'b0, 8'h3C, 32'h0);
        idle();
        drain();
`endif
        // Give every word a known value.
        for (int w = 0; w < 64; w++) issue(1'b1, 2'b10, 1'b0, 8'(w * 4), $urandom);

        // Lane merge.
        issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 8'h12, 32'h000000AB);
        issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);

        // Extension.
        issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h80FF7F01);
        issue(1'b0, 2'b00, 1'b0, 8'h22, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 8'h22, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 8'h22, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 8'h20, 32'h0);

        // Misaligned store then read the untouched words.
        issue(1'b1, 2'b10, 1'b0, 8'h06, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 8'h03, 32'h0);
        idle();
        drain();

        // Four back-to-back loads.
        for (int i = 0; i < 4; i++) issue(1'b0, 2'b10, 1'b0, 8'(8'h30 + 4 * i), 32'h0);
        idle();
        drain();

        // Randomized mix.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                r  = $urandom_range(0, 9);
                sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
                      8'($urandom_range(0, 255)), $urandom);
            end
        end
        idle();
        drain();

        // Reset with a load in flight.
        issue(1'b0, 2'b10, 1'b0, 8'h14, 32'h0);
        @(negedge i_clk);
        i_req = 1'b0;
        i_rst = 1'b1;
        q.delete();
        #1;
        check("midrst_rvalid", 32'(o_rvalid), 32'd0);
        check("midrst_busy",   32'(o_busy),   32'(EXP_BUSY_RST));
`ifdef DATA_RAM_CLEAR_EN
        model_clear();
`endif
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        busy_count("resweep_cycles");

        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 2);
            sz = 2'(r);
            issue(1'b0, sz, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 63) * 4), 32'h0);
        end
        idle();
        drain();
        repeat (LAT + 2) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
